// File: rtl/line_buffer_3row_if.sv
// ============================================================================
// line_buffer_3row_if : raster pixel stream in, three aligned row streams out
// Revision: 1.0
// ============================================================================
`default_nettype none

interface line_buffer_3row_if #(
   parameter int WIDTH = 24
);
   logic             valid_in;
   logic             sof;
   logic [WIDTH-1:0] din;
   logic             valid_out;
   logic [WIDTH-1:0] dout1;
   logic [WIDTH-1:0] dout2;
   logic [WIDTH-1:0] dout3;
   logic             frame_done;

   modport master (
      output valid_in, sof, din,
      input  valid_out, dout1, dout2, dout3, frame_done
   );

   modport slave (
      input  valid_in, sof, din,
      output valid_out, dout1, dout2, dout3, frame_done
   );
endinterface

`default_nettype wire

// File: rtl/line_buffer_3row.sv
// ============================================================================
// line_buffer_3row : two line memories turning a raster stream into 3-row columns
// Revision: 1.0
// ============================================================================
`default_nettype none

module line_buffer_3row #(
   parameter int PIC_WIDTH  = 250,
   parameter int PIC_HEIGHT = 250,
   parameter int WIDTH      = 24
) (
   input  wire logic         clk,
   input  wire logic         rst_n,
   line_buffer_3row_if.slave s
);

   localparam int         AW       = (PIC_WIDTH > 1) ? $clog2(PIC_WIDTH) : 1;
   localparam logic [10:0] COL_LAST = 11'(PIC_WIDTH - 1);
   localparam logic [10:0] ROW_LAST = 11'(PIC_HEIGHT - 1);

   logic [WIDTH-1:0] mem_a_q [PIC_WIDTH];
   logic [WIDTH-1:0] mem_b_q [PIC_WIDTH];

   logic [10:0]      col_q, col_d;
   logic [10:0]      row_q, row_d;
   logic             valid_out_q, valid_out_d;
   logic             frame_done_q, frame_done_d;
   logic [WIDTH-1:0] dout1_q, dout2_q, dout3_q;

   logic [10:0]      pos_col;
   logic [AW-1:0]    idx;
   logic [WIDTH-1:0] rd_a, rd_b;

   // A start-of-frame pixel always lands at column 0, whatever the counters say.
   assign pos_col = s.sof ? 11'd0 : col_q;
   assign idx     = pos_col[AW-1:0];
   assign rd_a    = mem_a_q[idx];
   assign rd_b    = mem_b_q[idx];

   always_comb begin
      col_d        = col_q;
      row_d        = row_q;
      valid_out_d  = 1'b0;
      frame_done_d = 1'b0;
      if (s.valid_in) begin
         if (s.sof) begin
            col_d = 11'd1;
            row_d = 11'd0;
         end else begin
            valid_out_d  = (row_q >= 11'd2);
            frame_done_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
            if (col_q == COL_LAST) begin
               col_d = 11'd0;
               row_d = (row_q == ROW_LAST) ? 11'd0 : row_q + 11'd1;
            end else begin
               col_d = col_q + 11'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (s.valid_in) begin
         mem_a_q[idx] <= s.din;
         mem_b_q[idx] <= rd_a;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q        <= 11'd0;
         row_q        <= 11'd0;
         valid_out_q  <= 1'b0;
         frame_done_q <= 1'b0;
         dout1_q      <= '0;
         dout2_q      <= '0;
         dout3_q      <= '0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         valid_out_q  <= valid_out_d;
         frame_done_q <= frame_done_d;
         if (s.valid_in) begin
            dout1_q <= rd_b;
            dout2_q <= rd_a;
            dout3_q <= s.din;
         end
      end
   end

   assign s.valid_out  = valid_out_q;
   assign s.frame_done = frame_done_q;
   assign s.dout1      = dout1_q;
   assign s.dout2      = dout2_q;
   assign s.dout3      = dout3_q;

endmodule

`default_nettype wire

// File: tb/tb_line_buffer_3row.sv
// ============================================================================
// tb_line_buffer_3row : directed bench for line_buffer_3row on a 4x4 frame
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_line_buffer_3row;

   localparam int PW = 4;
   localparam int PH = 4;
   localparam int W  = 24;

   typedef struct {
      logic [W-1:0] d1;
      logic [W-1:0] d2;
      logic [W-1:0] d3;
      logic         fd;
      int           cyc;
   } beat_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   beat_t        beats[$];
   int           n_checks = 0;
   int           n_fail   = 0;
   int           cyc      = 0;
   int           fd_cnt   = 0;
   int           t_acc    = 0;
   logic         acc_q    = 1'b0;
   logic         prev_rst_q = 1'b0;
   logic [W-1:0] p1 = '0, p2 = '0, p3 = '0;

   always #5 clk = ~clk;

   line_buffer_3row_if #(.WIDTH(W)) bus ();

   line_buffer_3row #(
      .PIC_WIDTH (PW),
      .PIC_HEIGHT(PH),
      .WIDTH     (W)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .s    (bus)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      acc_q <= bus.valid_in;
   end

   // After an idle cycle nothing may be flagged and the outputs must hold.
   always @(negedge clk) begin
      if (rst_n && prev_rst_q && !acc_q) begin
         check_eq("gap_valid_out", 32'(bus.valid_out), 32'd0);
         check_eq("gap_frame_done", 32'(bus.frame_done), 32'd0);
         check_eq("gap_dout1_hold", 32'(bus.dout1), 32'(p1));
         check_eq("gap_dout2_hold", 32'(bus.dout2), 32'(p2));
         check_eq("gap_dout3_hold", 32'(bus.dout3), 32'(p3));
      end
      if (rst_n && bus.valid_out)
         beats.push_back('{d1: bus.dout1, d2: bus.dout2, d3: bus.dout3,
                           fd: bus.frame_done, cyc: cyc});
      if (rst_n && bus.frame_done)
         fd_cnt <= fd_cnt + 1;
      prev_rst_q <= rst_n;
      p1 <= bus.dout1;
      p2 <= bus.dout2;
      p3 <= bus.dout3;
   end

   task automatic pix(input logic [W-1:0] d, input logic sf);
      @(negedge clk);
      bus.valid_in = 1'b1;
      bus.sof      = sf;
      bus.din      = d;
   endtask

   task automatic idle(input int n, input logic sf = 1'b0);
      repeat (n) begin
         @(negedge clk);
         bus.valid_in = 1'b0;
         bus.sof      = sf;
         bus.din      = 24'hABCDEF;
      end
   endtask

   task automatic frame(input logic [W-1:0] base, input int gap_pct, input int sof_gap_at);
      for (int k = 0; k < PW * PH; k++) begin
         if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct)
            idle($urandom_range(1, 2));
         if (k == sof_gap_at)
            idle(1, 1'b1);
         pix(base + 24'((k / PW) * 16 + (k % PW)), 1'b0);
         if (k == 2 * PW)
            t_acc = cyc + 1;
      end
   endtask

   task automatic check_frame(input int start, input logic [W-1:0] base, input string tag);
      for (int i = 0; i < PW * (PH - 2); i++) begin
         int r;
         int c;
         r = 2 + i / PW;
         c = i % PW;
         check_eq({tag, "_present"}, 32'(start + i < beats.size()), 32'd1);
         if (start + i < beats.size()) begin
            check_eq({tag, "_dout1"}, 32'(beats[start+i].d1), 32'(base + 24'((r - 2) * 16 + c)));
            check_eq({tag, "_dout2"}, 32'(beats[start+i].d2), 32'(base + 24'((r - 1) * 16 + c)));
            check_eq({tag, "_dout3"}, 32'(beats[start+i].d3), 32'(base + 24'(r * 16 + c)));
            check_eq({tag, "_frame_done"}, 32'(beats[start+i].fd), 32'(i == PW * (PH - 2) - 1));
         end
      end
   endtask

   task automatic check_cleared(input string tag);
      check_eq({tag, "_valid_out"}, 32'(bus.valid_out), 32'd0);
      check_eq({tag, "_frame_done"}, 32'(bus.frame_done), 32'd0);
      check_eq({tag, "_dout1"}, 32'(bus.dout1), 32'd0);
      check_eq({tag, "_dout2"}, 32'(bus.dout2), 32'd0);
      check_eq({tag, "_dout3"}, 32'(bus.dout3), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.valid_in = 1'b0;
      bus.sof      = 1'b0;
      bus.din      = '0;
      repeat (3) @(negedge clk);
      check_cleared("reset");
      check_eq("reset_col_cnt", 32'(dut.col_q), 32'd0);
      check_eq("reset_row_cnt", 32'(dut.row_q), 32'd0);
      rst_n = 1'b1;
      idle(2);

      // Continuous frame
      beats.delete();
      fd_cnt = 0;
      frame(24'h0, 0, -1);
      idle(3);
      check_eq("s1_beats", 32'(beats.size()), 32'd8);
      if (beats.size() == 8) begin
         check_eq("s1_first_latency", 32'(beats[0].cyc), 32'(t_acc));
         check_eq("s1_first_dout1", 32'(beats[0].d1), 32'h000000);
         check_eq("s1_first_dout2", 32'(beats[0].d2), 32'h000010);
         check_eq("s1_first_dout3", 32'(beats[0].d3), 32'h000020);
         check_eq("s1_last_dout1", 32'(beats[7].d1), 32'h13);
         check_eq("s1_last_dout2", 32'(beats[7].d2), 32'h23);
         check_eq("s1_last_dout3", 32'(beats[7].d3), 32'h33);
         check_eq("s1_last_frame_done", 32'(beats[7].fd), 32'd1);
      end
      check_frame(0, 24'h0, "s1");
      check_eq("s1_frame_done_count", 32'(fd_cnt), 32'd1);

      // Random idle cycles
      beats.delete();
      fd_cnt = 0;
      frame(24'h0, 40, -1);
      idle(3);
      check_eq("s2_beats", 32'(beats.size()), 32'd8);
      check_frame(0, 24'h0, "s2");
      check_eq("s2_frame_done_count", 32'(fd_cnt), 32'd1);

      // Back-to-back frames
      beats.delete();
      fd_cnt = 0;
      frame(24'h0, 0, -1);
      frame(24'h100, 0, -1);
      idle(3);
      check_eq("s3_beats", 32'(beats.size()), 32'd16);
      check_frame(0, 24'h0, "s3a");
      check_frame(8, 24'h100, "s3b");
      if (beats.size() == 16) begin
         check_eq("s3_f2_first_dout1", 32'(beats[8].d1), 32'h100);
         check_eq("s3_f2_first_dout2", 32'(beats[8].d2), 32'h110);
         check_eq("s3_f2_first_dout3", 32'(beats[8].d3), 32'h120);
      end
      check_eq("s3_frame_done_count", 32'(fd_cnt), 32'd2);

      // sof at pixel (2,1)
      beats.delete();
      fd_cnt = 0;
      for (int k = 0; k <= 2 * PW; k++)
         pix(24'((k / PW) * 16 + (k % PW)), 1'b0);
      pix(24'h200, 1'b1);
      for (int k = 1; k < PW * PH; k++)
         pix(24'h200 + 24'((k / PW) * 16 + (k % PW)), 1'b0);
      idle(3);
      check_eq("s4_beats", 32'(beats.size()), 32'd9);
      if (beats.size() == 9) begin
         check_eq("s4_pre_dout1", 32'(beats[0].d1), 32'h00);
         check_eq("s4_pre_dout2", 32'(beats[0].d2), 32'h10);
         check_eq("s4_pre_dout3", 32'(beats[0].d3), 32'h20);
      end
      check_frame(1, 24'h200, "s4");
      check_eq("s4_frame_done_count", 32'(fd_cnt), 32'd1);

      // Asynchronous reset in the middle of row 2
      for (int k = 0; k <= 2 * PW + 1; k++)
         pix(24'((k / PW) * 16 + (k % PW)), 1'b0);
      @(posedge clk);
      #1;
      check_eq("s5_pre_reset_valid", 32'(bus.valid_out), 32'd1);
      #1;
      rst_n        = 1'b0;
      bus.valid_in = 1'b0;
      #1;
      check_cleared("s5_async");
      repeat (2) @(negedge clk);
      check_cleared("s5_held");
      rst_n = 1'b1;
      idle(2);
      beats.delete();
      fd_cnt = 0;
      frame(24'h0, 0, -1);
      idle(3);
      check_eq("s5_beats", 32'(beats.size()), 32'd8);
      check_frame(0, 24'h0, "s5");
      check_eq("s5_frame_done_count", 32'(fd_cnt), 32'd1);

      // sof without valid_in mid-frame
      beats.delete();
      fd_cnt = 0;
      frame(24'h0, 0, 6);
      idle(3);
      check_eq("s6_beats", 32'(beats.size()), 32'd8);
      check_frame(0, 24'h0, "s6");
      check_eq("s6_frame_done_count", 32'(fd_cnt), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/line_buffer_3row.md
Name: line_buffer_3row

Overview:
- Upstream feeder for the 3x3 window/filter stage. Takes one raster-order pixel stream and presents three vertically aligned row streams: two rows above plus the current row, same column, same cycle.
- Two PIC_WIDTH-deep line memories hold the previous two rows.
- Emits valid_out only once a full 3-row column is available. The downstream stage shifts horizontally on every valid_out.

Parameters:
- PIC_WIDTH, 250: pixels per row; 2..2047.
- PIC_HEIGHT, 250: rows per frame; 3..2047.
- WIDTH, 24: pixel width ({R,G,B} 8 bits each).

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; asynchronous, active-low
- valid_in  input  1  din carries a pixel this cycle
- sof  input  1  qualified by valid_in; marks din as pixel (0,0) of a new frame
- din  input  WIDTH  incoming pixel, raster order
- valid_out  output  1  dout1..dout3 hold a valid column this cycle
- dout1  output  WIDTH  pixel at (row-2, col), top row
- dout2  output  WIDTH  pixel at (row-1, col), middle row
- dout3  output  WIDTH  pixel at (row, col), current row
- frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted

Behaviour:
- Reset state: valid_out=0, frame_done=0, dout1..3=0, col_cnt=0, row_cnt=0. Line memory contents are not reset; stale data is never flagged valid.
- Counters: col_cnt and row_cnt, 11 bits each; position of the next accepted pixel.
- Accepted pixel at (r,c): a cycle with valid_in=1. In that cycle:
  - read mem_a[c] (row r-1) and mem_b[c] (row r-2), read-before-write;
  - write mem_a[c]<=din and mem_b[c]<=old mem_a[c].
- Output register, latency 1 clock after acceptance: dout3<=din, dout2<=old mem_a[c], dout1<=old mem_b[c], valid_out<=(r>=2).
- Counter advance on each accepted pixel:
  - c<PIC_WIDTH-1: col_cnt+1.
  - Otherwise col_cnt<=0 and row_cnt+1.
  - At r=PIC_HEIGHT-1, c=PIC_WIDTH-1: row_cnt<=0, col_cnt<=0, and frame_done=1 on the next cycle, coinciding with the last valid_out.
- sof with valid_in: this pixel is treated as (0,0) regardless of the counters.
  - Memories are written at index 0.
  - valid_out<=0 for this pixel.
  - Counters become col=1, row=0; with PIC_WIDTH=1 not allowed, no wrap special case.
  - sof without valid_in is ignored.
- valid_in=0 (gap):
  - counters and memories hold; dout1..3 hold their last values;
  - valid_out=0 and frame_done=0 next cycle.
  - Gaps may occur anywhere, including mid-row. Output alignment is unaffected.
- Frame wrap: rows 0 and 1 of the next frame produce no valid_out, even though the memories hold the previous frame.
- Reset mid-frame: counters and outputs clear immediately (async). The next accepted pixel is (0,0) with or without sof.
- Throughput: one pixel per clock, with no backpressure. The downstream stage must accept every valid_out.
- Downstream window: sees valid_out for columns 0..PIC_WIDTH-1 of rows 2..PIC_HEIGHT-1. That is PIC_WIDTH*(PIC_HEIGHT-2) valid_out beats per frame.

Test Plan:
All scenarios use PIC_WIDTH=4, PIC_HEIGHT=4, WIDTH=24, and din=r*16+c.
- Continuous frame, no gaps:
  - first valid_out one clock after pixel (2,0) is accepted, with dout1=0x000000, dout2=0x000010, dout3=0x000020;
  - exactly 8 valid_out beats;
  - last beat dout1=0x13, dout2=0x23, dout3=0x33, with frame_done=1 in that same cycle.
- Random valid_in gaps (about 40% idle) on the same frame:
  - identical sequence of 8 valid_out triples;
  - valid_out=0 on every cycle following an idle cycle;
  - dout values held during gaps.
- Two back-to-back frames, second frame din=0x100+r*16+c:
  - no valid_out for the first 8 pixels of frame 2;
  - its first beat is dout1=0x100, dout2=0x110, dout3=0x120, with no stale frame-1 data flagged valid.
- sof asserted at pixel (2,1) of frame 1:
  - no valid_out for the next 8 accepted pixels;
  - counters restart, so the 9th accepted pixel after sof yields a valid column with correct new-frame data.
- rst_n pulsed low for 2 cycles mid-row 2:
  - valid_out, dout1..3 and frame_done go to 0 asynchronously;
  - a fresh frame then reproduces the scenario 1 results exactly.
- sof=1 with valid_in=0 at an arbitrary mid-frame cycle: no effect; the frame completes with the scenario 1 results.
